// File: rtl/t_pkg.sv
// Shared definitions for the toggle-strobe generator and the t_f flip-flop benches.
package t_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int NUM_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/t_strobe_gen_if.sv
// Control/status bundle between a strobe-generator client and t_strobe_gen.
interface t_strobe_gen_if
  import t_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [NUM_W-1:0] num_pulses;
  logic             t;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output start, stop, period, num_pulses,
    input  t, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, period, num_pulses,
    output t, busy, done, pulse_cnt
  );

endinterface

// File: rtl/t_strobe_div.sv
// Period counter: tick marks the last clock of each P-clock interval.
module t_strobe_div #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] P,
  output logic             tick
);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  assign tick = (div_cnt_q == P - CNT_W'(1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/t_strobe_gen.sv
// Programmable toggle-strobe source for t_f: single-cycle t pulses every P
// clocks, N times or continuously, followed by a one-cycle done pulse.
module t_strobe_gen
  import t_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  t_strobe_gen_if.slave ctrl
);

  state_t           state_q, state_d;
  logic             t_q, t_d;
  logic             done_q, done_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] pcnt_inc;
  logic             tick;

  // The divider is held clear outside RUN so every run starts at phase zero.
  t_strobe_div #(.CNT_W(CNT_W)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_RUN),
    .en   (state_q == ST_RUN),
    .P    (period_q),
    .tick (tick)
  );

  assign pcnt_inc = pcnt_q + NUM_W'(1);

  always_comb begin
    state_d  = state_q;
    t_d      = 1'b0;
    done_d   = 1'b0;
    pcnt_d   = pcnt_q;
    period_d = period_q;
    num_d    = num_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl.start) begin
          state_d  = ST_RUN;
          period_d = (ctrl.period == '0) ? CNT_W'(1) : ctrl.period;
          num_d    = ctrl.num_pulses;
          pcnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Abort wins over a coincident tick, so no pulse is emitted on that edge.
        if (ctrl.stop) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          t_d    = 1'b1;
          pcnt_d = pcnt_inc;
          if ((num_q != '0) && (pcnt_inc == num_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      t_q      <= 1'b0;
      done_q   <= 1'b0;
      pcnt_q   <= '0;
      period_q <= CNT_W'(1);
      num_q    <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      done_q   <= done_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      num_q    <= num_d;
    end
  end

  assign ctrl.t         = t_q;
  assign ctrl.done      = done_q;
  assign ctrl.pulse_cnt = pcnt_q;
  assign ctrl.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_t_strobe_gen.sv
// Bench for t_strobe_gen: directed scenarios plus randomized runs against a
// reference model that predicts pulses from elapsed clocks since start.
module tb_t_strobe_gen;
  import t_pkg::*;

  localparam int CW = 8;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic rst;

  t_strobe_gen_if #(.CNT_W(CW), .NUM_W(NW)) bus ();

  t_strobe_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  int nCmp  = 0;
  int nFail = 0;

  // Reference model: a run is described by its start edge, P and N; the
  // k-th edge after start carries a pulse when k is a multiple of P and
  // k <= N*P, and done follows at k = N*P+1.
  bit          mActive = 1'b0;
  int          mJ, mP, mN;
  logic [NW-1:0] mCnt = '0;
  bit          expT = 1'b0, expBusy = 1'b0, expDone = 1'b0;

  task automatic cycle(input bit s, input bit p, input bit r);
    bus.start = s;
    bus.stop  = p;
    rst       = r;
    @(posedge clk);
    expT    = 1'b0;
    expDone = 1'b0;
    if (r) begin
      mActive = 1'b0;
      mCnt    = '0;
    end else if (mActive) begin
      mJ = mJ + 1;
      if (mN != 0 && mJ == mN * mP + 1) begin
        expDone = 1'b1;
        mActive = 1'b0;
      end else if (p) begin
        mActive = 1'b0;
      end else if (mJ % mP == 0) begin
        expT = 1'b1;
        mCnt = mCnt + 1'b1;
      end
    end else if (s) begin
      mActive = 1'b1;
      mJ      = 0;
      mP      = (bus.period == '0) ? 1 : int'(bus.period);
      mN      = int'(bus.num_pulses);
      mCnt    = '0;
    end
    expBusy = mActive;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    bus.period     = 8'd7;
    bus.num_pulses = 8'd3;
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    nCmp++;
    if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
      nFail++;
      $display("[TB] FAIL reset got t/busy/done/cnt=%b/%b/%b/%0d want 0/0/0/0",
               bus.t, bus.busy, bus.done, bus.pulse_cnt);
    end
  endtask

  task automatic test_basic();
    int pulses = 0;
    bus.period     = 8'd3;
    bus.num_pulses = 8'd4;
    cycle(1, 0, 0);
    for (int e = 1; e <= 18; e++) begin
      cycle(0, 0, 0);
      if (bus.t) pulses++;
      nCmp++;
      if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {expT, expBusy, expDone, mCnt}) begin
        nFail++;
        $display("[TB] FAIL basic edge=%0d got t/busy/done/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 e, bus.t, bus.busy, bus.done, bus.pulse_cnt, expT, expBusy, expDone, mCnt);
      end
    end
    nCmp++;
    if (pulses != 4 || bus.pulse_cnt !== 8'd4) begin
      nFail++;
      $display("[TB] FAIL basic_total got pulses=%0d cnt=%0d want 4/4", pulses, bus.pulse_cnt);
    end
  endtask

  task automatic test_continuous();
    bus.period     = 8'd1;
    bus.num_pulses = 8'd0;
    cycle(1, 0, 0);
    for (int e = 1; e <= 300; e++) begin
      cycle(0, 0, 0);
      nCmp++;
      if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {expT, expBusy, expDone, mCnt}) begin
        nFail++;
        $display("[TB] FAIL continuous edge=%0d got t/busy/done/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 e, bus.t, bus.busy, bus.done, bus.pulse_cnt, expT, expBusy, expDone, mCnt);
      end
      if (e == 256) begin
        nCmp++;
        if (bus.pulse_cnt !== 8'd0 || bus.busy !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL wrap got cnt=%0d busy=%b want 0/1", bus.pulse_cnt, bus.busy);
        end
      end
    end
    cycle(0, 1, 0);
    nCmp++;
    if ({bus.t, bus.busy, bus.done} !== 3'b000 || bus.pulse_cnt !== mCnt) begin
      nFail++;
      $display("[TB] FAIL continuous_stop got t/busy/done/cnt=%b/%b/%b/%0d want 0/0/0/%0d",
               bus.t, bus.busy, bus.done, bus.pulse_cnt, mCnt);
    end
  endtask

  task automatic test_stop(input int stopEdge, input int wantCnt);
    bus.period     = 8'd4;
    bus.num_pulses = 8'd10;
    cycle(1, 0, 0);
    for (int e = 1; e <= 14; e++) begin
      cycle(0, e == stopEdge, 0);
      nCmp++;
      if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {expT, expBusy, expDone, mCnt}) begin
        nFail++;
        $display("[TB] FAIL stop%0d edge=%0d got t/busy/done/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 stopEdge, e, bus.t, bus.busy, bus.done, bus.pulse_cnt,
                 expT, expBusy, expDone, mCnt);
      end
    end
    nCmp++;
    if (bus.pulse_cnt !== wantCnt[NW-1:0] || bus.busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL stop%0d_total got cnt=%0d busy=%b want %0d/0",
               stopEdge, bus.pulse_cnt, bus.busy, wantCnt);
    end
  endtask

  task automatic test_reset_midrun();
    int firstT = -1;
    bus.period     = 8'd5;
    bus.num_pulses = 8'd3;
    cycle(1, 0, 0);
    for (int e = 1; e <= 30; e++) begin
      cycle(e == 9, 0, e == 7);
      if (e > 9 && bus.t && firstT < 0) firstT = e;
      nCmp++;
      if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {expT, expBusy, expDone, mCnt}) begin
        nFail++;
        $display("[TB] FAIL rst_midrun edge=%0d got t/busy/done/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 e, bus.t, bus.busy, bus.done, bus.pulse_cnt, expT, expBusy, expDone, mCnt);
      end
    end
    nCmp++;
    if (firstT != 14) begin
      nFail++;
      $display("[TB] FAIL restart_first_pulse got edge=%0d want 14", firstT);
    end
  endtask

  task automatic test_period_zero();
    int doneEdge = -1;
    bus.period     = 8'd0;
    bus.num_pulses = 8'd2;
    cycle(1, 0, 0);
    for (int e = 1; e <= 6; e++) begin
      cycle(e == 2, 0, 0);
      if (bus.done) doneEdge = e;
      nCmp++;
      if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {expT, expBusy, expDone, mCnt}) begin
        nFail++;
        $display("[TB] FAIL period0 edge=%0d got t/busy/done/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 e, bus.t, bus.busy, bus.done, bus.pulse_cnt, expT, expBusy, expDone, mCnt);
      end
    end
    nCmp++;
    if (doneEdge != 3) begin
      nFail++;
      $display("[TB] FAIL period0_done got edge=%0d want 3", doneEdge);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int len;
      bus.period     = CW'($urandom_range(0, 6));
      bus.num_pulses = NW'($urandom_range(0, 5));
      len = (bus.num_pulses == 0) ? 25 : int'(bus.num_pulses) * 6 + 4;
      cycle(1, 0, 0);
      for (int e = 1; e <= len; e++) begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 79) == 0);
        nCmp++;
        if ({bus.t, bus.busy, bus.done, bus.pulse_cnt} !== {expT, expBusy, expDone, mCnt}) begin
          nFail++;
          $display("[TB] FAIL random run=%0d edge=%0d got t/busy/done/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                   n, e, bus.t, bus.busy, bus.done, bus.pulse_cnt,
                   expT, expBusy, expDone, mCnt);
        end
      end
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.period     = '0;
    bus.num_pulses = '0;
    rst            = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    cycle(0, 0, 0);
    test_continuous();
    cycle(0, 0, 0);
    test_stop(9, 2);
    test_stop(8, 1);
    test_reset_midrun();
    cycle(0, 0, 1);
    test_period_zero();
    cycle(0, 0, 0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
